// File: rtl/simd_alu_pkg.sv
// Shared types and default geometry for the SIMD ALU pipeline.
package simd_alu_pkg;

  localparam int unsigned LANE_W_DEF = 8;
  localparam int unsigned LANES_DEF  = 32;

  typedef enum logic [2:0] {
    MODE_ADD  = 3'd0,
    MODE_AND  = 3'd1,
    MODE_OR   = 3'd2,
    MODE_XOR  = 3'd3,
    MODE_SUB  = 3'd4,
    MODE_MAXU = 3'd5,
    MODE_MINU = 3'd6,
    MODE_ACC  = 3'd7
  } mode_e;

endpackage

// File: rtl/simd_alu_lane.sv
// One SIMD lane: combinational op on the S1 operands plus the lane accumulator.
// Optional SIMD_ALU_SAT_EN saturates ADD/ACC to all-ones and SUB to zero.
module simd_alu_lane
  import simd_alu_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  mode_e             i_mode,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_res_c,
  output logic              o_carry_c
);

  logic [LANE_W-1:0] r_acc;
  logic [LANE_W-1:0] w_acc_eff;
  logic [LANE_W:0]   w_sum;
  logic [LANE_W:0]   w_acc_sum;
  logic              w_borrow;

  assign w_acc_eff = i_clr ? '0 : r_acc;
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_acc_sum = {1'b0, w_acc_eff} + {1'b0, i_a};
  assign w_borrow  = (i_a < i_b);

  always_comb begin
    o_res_c   = '0;
    o_carry_c = 1'b0;
    case (i_mode)
      MODE_ADD: begin
        o_res_c   = w_sum[LANE_W-1:0];
        o_carry_c = w_sum[LANE_W];
`ifdef SIMD_ALU_SAT_EN
        if (w_sum[LANE_W]) o_res_c = '1;
`endif
      end
      MODE_AND:  o_res_c = i_a & i_b;
      MODE_OR:   o_res_c = i_a | i_b;
      MODE_XOR:  o_res_c = i_a ^ i_b;
      MODE_SUB: begin
        o_res_c   = i_a - i_b;
        o_carry_c = w_borrow;
`ifdef SIMD_ALU_SAT_EN
        if (w_borrow) o_res_c = '0;
`endif
      end
      MODE_MAXU: o_res_c = (i_a >= i_b) ? i_a : i_b;
      MODE_MINU: o_res_c = (i_a <= i_b) ? i_a : i_b;
      MODE_ACC: begin
        o_res_c   = w_acc_sum[LANE_W-1:0];
        o_carry_c = w_acc_sum[LANE_W];
`ifdef SIMD_ALU_SAT_EN
        if (w_acc_sum[LANE_W]) o_res_c = '1;
`endif
      end
      default: ;
    endcase
  end

  // Accumulator only moves with the beat leaving S1, so stalls never re-accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      if (i_mode == MODE_ACC) r_acc <= o_res_c;
      else if (i_clr)         r_acc <= '0;
    end
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage valid/ready SIMD ALU: S1 holds operands, S2 holds the lane results.
// Build option SIMD_ALU_SAT_EN enables saturating ADD/SUB/ACC in every lane.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned LANES  = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W*LANES-1:0] in_op0,
  input  logic [LANE_W*LANES-1:0] in_op1,
  input  logic [2:0]              in_mode,
  input  logic                    in_acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_carry
);

  localparam int unsigned W = LANE_W * LANES;

  logic          r_run;
  logic          r_s1_valid;
  logic [W-1:0]  r_s1_a;
  logic [W-1:0]  r_s1_b;
  mode_e         r_s1_mode;
  logic          r_s1_clr;
  logic          r_s2_valid;
  logic [W-1:0]  r_s2_data;
  logic [LANES-1:0] r_s2_carry;

  logic          w_s1_adv;
  logic          w_move;
  logic          w_in_xfer;
  logic [W-1:0]  w_res;
  logic [LANES-1:0] w_carry;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign w_move    = r_s1_valid && w_s1_adv;
  assign in_ready  = r_run && (!r_s1_valid || w_s1_adv);
  assign w_in_xfer = in_valid && in_ready;

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_carry = r_s2_carry;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= MODE_ADD;
      r_s1_clr   <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_op0;
      r_s1_b     <= in_op1;
      r_s1_mode  <= mode_e'(in_mode);
      r_s1_clr   <= in_acc_clr;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_carry <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= w_res;
        r_s2_carry <= w_carry;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_alu_lane #(.LANE_W(LANE_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (w_move),
      .i_clr     (r_s1_clr),
      .i_mode    (r_s1_mode),
      .i_a       (r_s1_a[LANE_W*g +: LANE_W]),
      .i_b       (r_s1_b[LANE_W*g +: LANE_W]),
      .o_res_c   (w_res[LANE_W*g +: LANE_W]),
      .o_carry_c (w_carry[g])
    );
  end

endmodule

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 SHALL have parameter LANE_W, default 8: bits per lane.
REQ-002 SHALL have parameter LANES, default 32: lane count; total data width is W = LANE_W*LANES (256 by default).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  block can accept a beat.
REQ-007 in_op0  in  W  operand A, lane i = bits [LANE_W*i +: LANE_W].
REQ-008 in_op1  in  W  operand B, same lane mapping.
REQ-009 in_mode  in  3  operation select: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB (A-B), 5 MAXU, 6 MINU, 7 ACC.
REQ-010 in_acc_clr  in  1  zero the lane accumulators before this beat executes.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_data  out  W  per-lane result.
REQ-014 out_carry  out  LANES  per-lane carry (ADD/ACC) or borrow (SUB); 0 for the other modes.

Function
REQ-015 A beat SHALL transfer on input when in_valid&&in_ready and on output when out_valid&&out_ready.
REQ-016 The block SHALL be a 2-stage pipeline: S1 registers the operands, mode and clear; S2 registers the computed result. Latency is exactly 2 cycles from the input transfer to out_valid when there is no stall.
REQ-017 in_ready SHALL equal !S1.valid || S1 advances, where S1 advances if !S2.valid || out_ready. Sustained throughput is 1 beat/cycle.
REQ-018 While out_valid && !out_ready, out_data, out_carry and out_valid SHALL hold stable. No beat is dropped or duplicated.
REQ-019 Lanes SHALL be independent: no carry or borrow propagates across lane boundaries.
REQ-020 ADD/SUB SHALL use unsigned LANE_W arithmetic. Carry is bit LANE_W of A+B; borrow is A<B.
REQ-021 MAXU/MINU SHALL compare lanes unsigned; on A==B the result is A.
REQ-022 Each lane SHALL hold an LANE_W accumulator acc[i]. ACC result = acc[i]+A[i] (B ignored); acc[i] takes the result when the beat moves S1 to S2.
REQ-023 in_acc_clr SHALL be applied in beat order. When the beat reaches S2, acc is treated as 0 before its operation. For a non-ACC mode, acc becomes 0.
REQ-024 Accumulator updates SHALL occur only on the S1-to-S2 move. A stalled beat does not re-accumulate.
REQ-025 Input content SHALL be ignored when in_valid=0. The mode value is ignored unless the beat transfers.

Reset
REQ-026 While rst_n=0: S1/S2 valid=0, out_valid=0, out_data=0, out_carry=0, acc[*]=0, in_ready=0.
REQ-027 in_ready SHALL go 1 in the first cycle after rst_n deasserts.
REQ-028 A reset mid-operation SHALL discard all in-flight beats and accumulator contents.

Configuration
REQ-029 Macro SIMD_ALU_SAT_EN: when defined, ADD and ACC saturate to all-ones on carry and SUB saturates to 0 on borrow; out_carry still reports the carry/borrow.
REQ-030 Without SIMD_ALU_SAT_EN, ADD/SUB/ACC SHALL wrap modulo 2^LANE_W.

Structure
REQ-031 A shared package simd_alu_pkg SHALL hold the mode typedef (3-bit enum, the eight codes above) and the default LANE_W/LANES constants.
REQ-032 The per-lane compute and accumulator SHALL be one sub-module, simd_alu_lane, instantiated LANES times via generate. The pipeline/handshake control lives in the top module only.

Verification (LANE_W=8, LANES=32)
REQ-033 ADD with lane0 A=0xF0, B=0x20, out_ready=1 -> 2 cycles later lane0=0x10 with carry=1, or lane0=0xFF with SIMD_ALU_SAT_EN; lane1 is unaffected by the lane0 carry.
REQ-034 SUB A=0x05, B=0x07 -> lane=0xFE with borrow=1, or 0x00 with SIMD_ALU_SAT_EN. MAXU/MINU A=0x80, B=0x7F -> 0x80 / 0x7F.
REQ-035 ACC stream: A=3 with in_acc_clr=1, then A=4, then A=5 -> outputs 3, 7, 12. The next beat with clr=1 and A=1 -> 1.
REQ-036 Back-to-back 8 beats with out_ready held low for 5 cycles mid-stream -> out_data stable while stalled, in_ready=0 once S1 and S2 are full, all 8 results in order, no accumulator double-count.
REQ-037 Assert rst_n=0 with 2 beats in flight and acc=0x33 -> out_valid=0 immediately; after release the first ACC beat A=1 without clr -> 0x01.
REQ-038 Random beats with in_valid/out_ready randomly toggled, checked against a lane-wise reference model -> zero mismatches over 10k beats.
